// File: rtl/ps2_key_sequencer_if.sv
// ps2_key_sequencer_if: key-event stream from the PS/2 sequencer to its consumer.
// valid/ready handshake; an entry transfers when keyValid && keyReady.
interface ps2_key_sequencer_if;
    logic [7:0] keyData;
    logic       keyBreak;
    logic       keyValid;
    logic       keyReady;
    modport master (output keyData, keyBreak, keyValid, input keyReady);
    modport slave  (input keyData, keyBreak, keyValid, output keyReady);
endinterface

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: PS/2 frame deframer, set-2 prefix decoder and ASCII key-event FIFO.
// kbdClk/kbdDataIn are synchronised into clk; falling edges of kbdClk step the frame FSM.
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  kbdClk,
    input  logic                  kbdDataIn,
    ps2_key_sequencer_if.master   key,
    output logic                  frameError,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      kclk_q, kdat_q;
    logic            kclk_prev_q;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            byte_v_q, byte_v_d;
    logic [7:0]      byte_q;
    logic            brk_q, brk_d, ext_q, ext_d;
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [AW:0]     cnt_q;
    logic            fall, din, timeout, push, pop, full, wr;
    logic [7:0]      ascii;

    function automatic logic [7:0] map(input logic [7:0] c);
        case (c)
            8'h1C: return "A"; 8'h32: return "B"; 8'h21: return "C"; 8'h23: return "D";
            8'h24: return "E"; 8'h2B: return "F"; 8'h34: return "G"; 8'h33: return "H";
            8'h43: return "I"; 8'h3B: return "J"; 8'h42: return "K"; 8'h4B: return "L";
            8'h3A: return "M"; 8'h31: return "N"; 8'h44: return "O"; 8'h4D: return "P";
            8'h15: return "Q"; 8'h2D: return "R"; 8'h1B: return "S"; 8'h2C: return "T";
            8'h3C: return "U"; 8'h2A: return "V"; 8'h1D: return "W"; 8'h22: return "X";
            8'h35: return "Y"; 8'h1A: return "Z";
            8'h45: return "0"; 8'h16: return "1"; 8'h1E: return "2"; 8'h26: return "3";
            8'h25: return "4"; 8'h2E: return "5"; 8'h36: return "6"; 8'h3D: return "7";
            8'h3E: return "8"; 8'h46: return "9";
            8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    assign din  = kdat_q[1];
    assign fall = kclk_prev_q & ~kclk_q[1];

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_v_d   = 1'b0;
        frameError = 1'b0;
        timeout    = state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1);
        tmo_d      = (fall || state_q == IDLE || timeout) ? '0 : tmo_q + 1'b1;
        if (timeout) begin
            state_d    = IDLE;
            frameError = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = din ? IDLE : DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    shift_d = {din, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = bit_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                default: begin
                    state_d    = IDLE;
                    byte_v_d   = din & (^{shift_q, par_q});
                    frameError = ~byte_v_d;
                end
            endcase
        end
    end

    // F0 only marks a release, E0 only marks an extended code; any other byte consumes both flags
    assign ascii = map(byte_q);
    assign push  = byte_v_q && byte_q != 8'hF0 && byte_q != 8'hE0 && !ext_q && ascii != 8'h00;
    assign brk_d = !byte_v_q ? brk_q : byte_q == 8'hF0 ? 1'b1 : byte_q == 8'hE0 ? brk_q : 1'b0;
    assign ext_d = !byte_v_q ? ext_q : byte_q == 8'hE0 ? 1'b1 : byte_q == 8'hF0 ? ext_q : 1'b0;

    assign key.keyValid = cnt_q != '0;
    assign key.keyData  = key.keyValid ? mem_q[rp_q][7:0] : 8'h00;
    assign key.keyBreak = key.keyValid & mem_q[rp_q][8];
    assign pop  = key.keyValid && key.keyReady;
    assign full = cnt_q == FULL;
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            kclk_q      <= '1;
            kdat_q      <= '1;
            kclk_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_v_q    <= 1'b0;
            byte_q      <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            overflow    <= 1'b0;
        end else begin
            kclk_q      <= {kclk_q[0], kbdClk};
            kdat_q      <= {kdat_q[0], kbdDataIn};
            kclk_prev_q <= kclk_q[1];
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_v_q    <= byte_v_d;
            if (byte_v_d) byte_q <= shift_q;
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            wp_q        <= wp_q + AW'(wr);
            rp_q        <= rp_q + AW'(pop);
            cnt_q       <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= {brk_q, ascii};
    end
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: directed PS/2 frames against a queue of expected key events.
// Expected {break, ascii} entries are queued as frames are sent and compared on each pop.
module tb_ps2_key_sequencer;
    logic clk = 1'b0, reset = 1'b1, kbdClk = 1'b1, kbdDataIn = 1'b1;
    logic frameError, overflow;
    int checks = 0, errors = 0, fe_cnt = 0, fe_base;
    logic [8:0] sb[$];
    logic [8:0] e;

    ps2_key_sequencer_if key();

    ps2_key_sequencer dut (
        .clk(clk), .reset(reset), .kbdClk(kbdClk), .kbdDataIn(kbdDataIn),
        .key(key), .frameError(frameError), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (frameError) fe_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        kbdDataIn = b;
        repeat (10) @(negedge clk);
        kbdClk = 1'b0;
        repeat (20) @(negedge clk);
        kbdClk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pbad, input logic stopv, input int nb);
        logic [10:0] fr;
        fr = {stopv, (~^b) ^ pbad, b, 1'b0};
        for (int i = 0; i < nb; i++) send_bit(fr[i]);
        kbdDataIn = 1'b1;
    endtask

    // stop bit driven low-edge only; caller observes the handshake while kbdClk is low
    task automatic stop_edge();
        @(negedge clk);
        kbdDataIn = 1'b1;
        repeat (10) @(negedge clk);
        kbdClk = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            int t;
            t = 0;
            @(negedge clk);
            while (!key.keyValid && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("valid_wait", key.keyValid, 1);
            e = sb.pop_front();
            check("key_data", key.keyData, e[7:0]);
            check("key_break", key.keyBreak, e[8]);
            key.keyReady = 1'b1;
            @(negedge clk);
            key.keyReady = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] codes [9];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        key.keyReady = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data", key.keyData, 0);
        check("rst_break", key.keyBreak, 0);
        check("rst_valid", key.keyValid, 0);
        check("rst_ferr", frameError, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // latency and hold of a single make code
        send_frame(8'h1C, 1'b0, 1'b1, 10);
        stop_edge();
        sb.push_back({1'b0, 8'h41});
        repeat (3) @(posedge clk);
        #1 check("valid_e1", key.keyValid, 0);
        @(posedge clk);
        #1 check("valid_e2", key.keyValid, 1);
        repeat (15) @(negedge clk);
        kbdClk = 1'b1;
        repeat (40) @(negedge clk);
        check("hold_valid", key.keyValid, 1);
        check("hold_data", key.keyData, 8'h41);
        drain();
        check("empty_after_pop", key.keyValid, 0);

        // prefixes: F0 16 -> release '1'; E0 75 dropped; 1C clean afterwards
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        send_frame(8'h16, 1'b0, 1'b1, 11);
        sb.push_back({1'b1, 8'h31});
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'h75, 1'b0, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        sb.push_back({1'b0, 8'h41});
        drain();
        repeat (5) @(negedge clk);
        check("prefix_empty", key.keyValid, 0);

        // parity, stop and start-bit errors
        fe_base = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        repeat (20) @(negedge clk);
        check("parity_ferr", fe_cnt - fe_base, 1);
        check("parity_empty", key.keyValid, 0);
        fe_base = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        repeat (20) @(negedge clk);
        check("stop_ferr", fe_cnt - fe_base, 1);
        check("stop_empty", key.keyValid, 0);
        fe_base = fe_cnt;
        for (int i = 0; i < 11; i++) send_bit(1'b1);
        repeat (20) @(negedge clk);
        check("start1_ferr", fe_cnt - fe_base, 0);
        check("start1_empty", key.keyValid, 0);

        // timeout after 4 data bits, then a clean frame
        fe_base = fe_cnt;
        send_frame(8'h2B, 1'b0, 1'b1, 5);
        repeat (5100) @(negedge clk);
        check("timeout_ferr", fe_cnt - fe_base, 1);
        check("timeout_empty", key.keyValid, 0);
        send_frame(8'h2B, 1'b0, 1'b1, 11);
        sb.push_back({1'b0, 8'h46});
        drain();

        // overflow: nine events into an eight-deep FIFO
        for (int i = 0; i < 9; i++) begin
            send_frame(codes[i], 1'b0, 1'b1, 11);
            if (i < 8) sb.push_back({1'b0, 8'h41 + 8'(i)});
        end
        repeat (5) @(negedge clk);
        check("ovf_set", overflow, 1);
        drain();
        check("ovf_drained", key.keyValid, 0);

        // push coinciding with a pop while full
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("ovf_cleared", overflow, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_frame(codes[i], 1'b0, 1'b1, 11);
            sb.push_back({1'b0, 8'h41 + 8'(i)});
        end
        send_frame(8'h1A, 1'b0, 1'b1, 10);
        stop_edge();
        repeat (3) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("head_at_pop", key.keyData, e[7:0]);
        key.keyReady = 1'b1;
        sb.push_back({1'b0, 8'h5A});
        @(negedge clk);
        key.keyReady = 1'b0;
        repeat (10) @(negedge clk);
        kbdClk = 1'b1;
        repeat (10) @(negedge clk);
        check("pushpop_no_ovf", overflow, 0);
        drain();

        // reset mid-frame, then a clean frame
        send_frame(8'h45, 1'b0, 1'b1, 5);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_data", key.keyData, 0);
        check("mid_rst_break", key.keyBreak, 0);
        check("mid_rst_valid", key.keyValid, 0);
        check("mid_rst_ferr", frameError, 0);
        check("mid_rst_ovf", overflow, 0);
        reset = 1'b0;
        fe_base = fe_cnt;
        send_frame(8'h45, 1'b0, 1'b1, 11);
        sb.push_back({1'b0, 8'h30});
        drain();
        check("post_rst_ferr", fe_cnt - fe_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
System-clock controller that sequences PS/2 keyboard reception.
- Samples the asynchronous kbdClk/kbdDataIn lines and deframes 11-bit PS/2 frames.
- Runs the scan-code-set-2 prefix state machine (E0/F0), translates make/break codes to ASCII and queues key events in a FIFO.
- Sits between the keyboard pins and the CPU I/O port; replaces direct kbdClk-clocked capture with a single clock domain and a valid/ready handshake.

Parameters:
FIFO_DEPTH, 8, number of key events buffered (power of two, >=2)
TIMEOUT_CYCLES, 5000, clk cycles without a kbdClk falling edge before a partial frame is aborted

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
kbdClk  input  1  PS/2 clock line, asynchronous to clk
kbdDataIn  input  1  PS/2 data line, asynchronous to clk
keyData  output  8  ASCII code of FIFO head entry
keyBreak  output  1  1 = head entry is a key release, 0 = key press
keyValid  output  1  FIFO non-empty; keyData/keyBreak are valid
keyReady  input  1  consumer accepts head entry when keyValid && keyReady
frameError  output  1  one-cycle pulse on parity, start, stop or timeout error
overflow  output  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset clears the synchronisers (to 1), all FSMs to idle, FIFO pointers/count, prefix flags and the timeout counter. Outputs after reset: keyData=0, keyBreak=0, keyValid=0, frameError=0, overflow=0. Reset mid-frame discards the partial frame with no error.
- Sync: kbdClk and kbdDataIn each pass through 2 flip-flops. A falling edge is registered previous=1, current=0. Data is sampled from the synchronised kbdDataIn in the same cycle.
- Frame FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE; one transition per falling edge.
  - IDLE: start bit must be 0. A 1 keeps IDLE with no error.
  - PARITY: odd parity is required; XOR of the 8 data bits and the parity bit must be 1.
  - STOP: stop bit must be 1.
  - A parity or stop failure pulses frameError at the STOP edge cycle and discards the byte.
- Timeout: the counter clears on each falling edge and in IDLE. If it reaches TIMEOUT_CYCLES in any non-IDLE state: FSM -> IDLE, frameError pulses for 1 cycle, the byte is discarded.
- Byte valid: asserted internally for 1 cycle at E, where E is the cycle the STOP edge is detected.
- Prefix FSM acts at E+1:
  - Byte 0xF0 sets breakFlag.
  - Byte 0xE0 sets extFlag.
  - Any other byte: if extFlag, discard. Otherwise map it and push {breakFlag, ascii} if ascii != 0; discard if unmapped. In all three cases both flags clear.
- Map: set-2 letters map to uppercase ASCII 'A'..'Z' (e.g. 1C->'A', 32->'B', 1A->'Z'). Digits map to '0'..'9' (45->'0', 16->'1', 46->'9'). 29->0x20, 5A->0x0D, 66->0x08. All other codes map to 0.
- FIFO:
  - A push written at E+1 makes keyValid high at E+2 if the FIFO was empty.
  - Pop on keyValid && keyReady; the next entry appears the following cycle.
  - Push when full with no pop in the same cycle: the entry is dropped and overflow is set to 1, cleared only by reset.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- keyData/keyBreak are 0 when the FIFO is empty.

Test Plan:
- Frame 1C (start 0, data LSB-first, parity 0, stop 1), keyReady=0 -> keyValid=1 two clk after STOP edge detection, keyData=0x41, keyBreak=0; holds until keyReady=1, then keyValid=0 next cycle.
- Frames F0,16 -> one entry keyData=0x31, keyBreak=1; frames E0,75 -> no entry. A following 1C still yields 0x41, keyBreak=0 (flags cleared).
- Frame 1C with parity bit 1 -> frameError pulses 1 cycle, no entry. Stop bit 0 -> same. Start bit 1 held -> no error, FIFO empty.
- 4 data bits then kbdClk held high for TIMEOUT_CYCLES -> frameError pulses once. A subsequent clean 2B frame yields 0x46.
- FIFO_DEPTH+1 mapped frames with keyReady=0 -> overflow=1, first FIFO_DEPTH entries pop in order. Push coinciding with a pop when full -> no overflow.
- Reset asserted mid-frame (after 5 bits) -> all outputs 0. Next full 45 frame yields 0x30 with no frameError.
